// File: rtl/riscv_data_mem.sv
// Data memory for a simple RISC-V core: one load/store per 3 cycles (IDLE -> ACCESS -> RESP), no pipelining.
// Define RISCV_DMEM_ERR_CHECK_EN to flag misaligned, illegal-funct3 and out-of-range accesses.
module riscv_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                  state_q;
  logic                    rdy_q;
  logic [31:0]             addr_q;
  logic [2:0]              f3_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0]           idx;
  logic [1:0]              lane;
  logic [DATA_WIDTH-1:0]   word;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic                    err_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic [DATA_WIDTH-1:0]   wword_d;
  logic [3:0]              be_d;

  // Index simply drops the upper address bits, so without error checking it wraps.
  assign idx      = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign word     = mem_q[idx];
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

`ifdef RISCV_DMEM_ERR_CHECK_EN
  always_comb begin
    err_d = (addr_q[31:AW+2] != '0);
    if (we_q) begin
      case (f3_q)
        3'b000:  ;
        3'b001:  if (lane[0]) err_d = 1'b1;
        3'b010:  if (lane != 2'b00) err_d = 1'b1;
        default: err_d = 1'b1;
      endcase
    end else begin
      case (f3_q)
        3'b000, 3'b100: ;
        3'b001, 3'b101: if (lane[0]) err_d = 1'b1;
        3'b010:         if (lane != 2'b00) err_d = 1'b1;
        default:        err_d = 1'b1;
      endcase
    end
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:AW+2];
  assign err_d          = 1'b0;
`endif

  // Unknown load encodings fall through to a full-word read.
  always_comb begin
    rdata_d = word;
    case (f3_q)
      3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  rdata_d = {24'h0, byte_sel};
      3'b101:  rdata_d = {16'h0, half_sel};
      default: rdata_d = word;
    endcase
  end

  always_comb begin
    be_d    = 4'hF;
    wword_d = wdata_q;
    case (f3_q)
      3'b000: begin
        be_d    = 4'b0001 << lane;
        wword_d = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        be_d    = lane[1] ? 4'b1100 : 4'b0011;
        wword_d = {2{wdata_q[15:0]}};
      end
      default: begin
        be_d    = 4'hF;
        wword_d = wdata_q;
      end
    endcase
  end

  // Array has no reset; a reset landing on the ACCESS edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACCESS && we_q && !err_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[idx][8*b +: 8] <= wword_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      addr_q      <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            state_q <= ACCESS;
            rdy_q   <= 1'b0;
            addr_q  <= req_addr_i;
            f3_q    <= req_funct3_i;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_d;
          rsp_rdata_q <= (we_q || err_d) ? '0 : rdata_d;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = rdy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/riscv_data_mem.md
RISCV_DATA_MEM -- requirements
Module: riscv_data_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit memory words (power of two).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width (only 32 supported).
REQ-003 Port clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  is the reset, which is synchronous and active-high.
REQ-005 Port req_valid_i  input  1  means the core presents a load/store request.
REQ-006 Port req_ready_o  output  1  means the block accepts the request this cycle.
REQ-007 Port req_we_i  input  1  selects the access type: 1 = store, 0 = load.
REQ-008 Port req_funct3_i  input  3  is the funct3 field, using the load (LB/LH/LW/LBU/LHU) or store (SB/SH/SW) encodings of riscv_definitions.
REQ-009 Port req_addr_i  input  32  is the byte address.
REQ-010 Port req_wdata_i  input  32  is the store data, right-aligned.
REQ-011 Port rsp_valid_o  output  1  means a response is available.
REQ-012 Port rsp_ready_i  input  1  means the core accepts the response.
REQ-013 Port rsp_rdata_o  output  32  is the extended load data (0 for stores and errors).
REQ-014 Port rsp_err_o  output  1  flags a misaligned, illegal-funct3 or out-of-range access.

Function
REQ-015 The FSM SHALL have three states, IDLE, ACCESS and RESP, encoded as an enum.
REQ-016 req_ready_o SHALL be 1 only in IDLE; valid&ready transfers the request and moves the FSM to ACCESS, with the address, funct3, we and wdata captured.
REQ-017 In ACCESS, the array read/write SHALL occur at the closing edge; the FSM then goes to RESP, so rsp_valid_o rises 2 cycles after the accept edge.
REQ-018 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL hold stable until rsp_valid_o&rsp_ready_i; that edge returns the FSM to IDLE.
REQ-019 After response completion, a new request SHALL be accepted no earlier than the following cycle, giving a minimum of 3 cycles per access with no pipelining.
REQ-020 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2], and the byte lane SHALL be addr[1:0].
REQ-021 SB SHALL write wdata[7:0] to the addressed lane; SH SHALL write wdata[15:0] to lanes {addr[1],0}; SW SHALL write all 4 lanes; other lanes are unchanged.
REQ-022 Loads SHALL extract data from the addressed lane(s): LB and LH sign-extend; LBU and LHU zero-extend; LW returns the word.
REQ-023 An error SHALL be raised for any of the following: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]!=0; load funct3 of 3, 6 or 7; store funct3 >= 3; or addr[31:2] >= DEPTH_WORDS.
REQ-024 On error, no array write SHALL occur, rsp_err_o SHALL be 1 and rsp_rdata_o SHALL be 0; the response handshake is otherwise unchanged.
REQ-025 Store responses SHALL have rsp_rdata_o=0 and rsp_err_o=0 unless an error is raised.
REQ-026 A load issued after a completed store to the same address SHALL return the stored data, since no write buffer exists.
REQ-027 Request inputs SHALL be ignored outside IDLE; req_valid_i held high during ACCESS or RESP is not double-accepted.

Reset
REQ-028 While rst is high at a rising edge: FSM=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, all captured request registers=0; req_ready_o is 1 from the first cycle after rst deasserts.
REQ-029 rst asserted during ACCESS SHALL suppress the pending array write; rst during RESP SHALL drop the response.
REQ-030 Memory array contents SHALL NOT be affected by reset.

Configuration
REQ-031 The macro RISCV_DMEM_ERR_CHECK_EN SHALL, when defined, enable the REQ-023/REQ-024 error detection.
REQ-032 Without RISCV_DMEM_ERR_CHECK_EN, rsp_err_o SHALL be tied 0, illegal funct3 SHALL be treated as LW/SW, misaligned addresses SHALL use the lowest aligned lane(s), and the word index SHALL wrap modulo DEPTH_WORDS.

Verification
REQ-033 Reset -> rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=1 on the first cycle after rst falls.
REQ-034 SW 0x8000_00F1 @0x10, then LB @0x10, LBU @0x10, LH @0x12, LW @0x10 -> 0xFFFF_FFF1, 0x0000_00F1, 0xFFFF_8000, 0x8000_00F1; each rsp_valid_o rises 2 cycles after its accept.
REQ-035 SW 0 @0x20, SB 0xAB @0x23, SH 0x1234 @0x20 -> LW @0x20 returns 0xAB00_1234.
REQ-036 With the macro defined: LW @0x22, SH @0x21, LB funct3=3 @0x0, LW @(4*DEPTH_WORDS) -> each has rsp_err_o=1 and rdata=0; a following LW @0x20 is unchanged.
REQ-037 With rsp_ready_i held low for 5 cycles in RESP -> rsp_valid_o, rsp_rdata_o and rsp_err_o stay stable and req_ready_o stays 0; completion happens on the first high cycle.
REQ-038 rst pulsed during the ACCESS cycle of SW 0xDEAD_BEEF @0x40 (previously 0) -> no response, and a later LW @0x40 returns 0.
